// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detection with glitch rejection, 3-sample majority vote,
// LSB-first deserialisation, parity/stop checking and one-cycle result strobes.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0]            BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]            BIT_ONE  = BCW'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO      = PRESCALE_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, next_state;

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] p_reg;
    logic                      par_en_r;
    logic                      par_typ_r;
    logic [BCW-1:0]            bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      s0, s1;
    logic                      par_flag, stp_flag;

    logic [PRESCALE_WIDTH-1:0] half, last;
    logic at_s0, at_s1, at_vote, at_last, bit_last, vote, exp_par, glitch;

    always_comb begin
        half     = p_reg >> 1;
        last     = p_reg - ONE;
        at_s0    = (edge_cnt == half - TWO);
        at_s1    = (edge_cnt == half - ONE);
        at_vote  = (edge_cnt == half);
        at_last  = (edge_cnt == last);
        bit_last = (bit_cnt == BIT_LAST);
        // third sample is the live line value at edge P/2
        vote     = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
        exp_par  = (^shift_reg) ^ par_typ_r;
        glitch   = (state == START) && at_vote && vote;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START: begin
                if (glitch)       next_state = IDLE;
                else if (at_last) next_state = DATA;
            end
            DATA:    if (at_last && bit_last) next_state = par_en_r ? PARITY : STOP;
            PARITY:  if (at_last) next_state = STOP;
            STOP:    if (at_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cnt   <= '0;
            p_reg      <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state == IDLE) begin
                if (!RX_IN) begin
                    // the detection cycle is edge 0 of the start bit
                    edge_cnt  <= ONE;
                    p_reg     <= Prescale;
                    par_en_r  <= PAR_EN;
                    par_typ_r <= PAR_TYP;
                    bit_cnt   <= '0;
                    par_flag  <= 1'b0;
                    stp_flag  <= 1'b0;
                end else begin
                    edge_cnt <= '0;
                end
            end else begin
                edge_cnt <= (at_last || glitch) ? '0 : edge_cnt + ONE;
                if (at_s0) s0 <= RX_IN;
                if (at_s1) s1 <= RX_IN;
            end

            case (state)
                DATA: begin
                    if (at_vote) shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
                    if (at_last) bit_cnt <= bit_last ? '0 : bit_cnt + BIT_ONE;
                end
                PARITY: begin
                    if (at_vote) par_flag <= (vote != exp_par);
                end
                STOP: begin
                    if (at_vote) stp_flag <= ~vote;
                    if (at_last) begin
                        if (!par_flag && !stp_flag) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            par_err <= par_flag;
                            stp_err <= stp_flag;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frames are generated bit-cell by bit-cell and the
// expected strobe time/content comes from the frame format and latency rule.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct packed {
        int unsigned cyc;
        logic [7:0]  data;
        logic        dv;
        logic        pe;
        logic        se;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          dv, pe_o, se_o;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .RX_IN(rx), .Prescale(prescale),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
        .data_valid(dv), .par_err(pe_o), .stp_err(se_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         flip_mode = 0;   // 0 none, 1 flip at P/2-1, 2 flip one random sample point
    bit         scramble = 1'b0; // randomise config inputs after the start bit

    always @(negedge clk)
        if (dv || pe_o || se_o) obs_q.push_back(ev_t'{cyc, p_data, dv, pe_o, se_o});

    task automatic drive_cell(input logic v, input int unsigned p, output int unsigned c0);
        int unsigned fp;
        case (flip_mode)
            1:       fp = p / 2 - 1;
            2:       fp = p / 2 - 2 + $urandom_range(0, 2);
            default: fp = p;
        endcase
        c0 = 0;
        for (int unsigned i = 0; i < p; i++) begin
            @(negedge clk);
            if (i == 0) c0 = cyc;
            rx = (i == fp) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic pen,
                              input logic ptyp, input logic bad_par, input logic stop_v);
        int unsigned c0, dummy;
        ev_t e;
        prescale = PW'(p);
        par_en   = pen;
        par_typ  = ptyp;
        drive_cell(1'b0, p, c0);
        if (scramble) begin
            prescale = PW'(8 << $urandom_range(0, 2));
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
        end
        for (int i = 0; i < DW; i++) drive_cell(d[i], p, dummy);
        if (pen) drive_cell((^d) ^ ptyp ^ bad_par, p, dummy);
        drive_cell(stop_v, p, dummy);
        e.cyc = c0 + (DW + 2 + (pen ? 1 : 0)) * p;
        e.pe  = pen & bad_par;
        e.se  = ~stop_v;
        e.dv  = ~e.pe & ~e.se;
        if (e.dv) model_data = d;
        e.data = model_data;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", dv); end
        checks++; if (pe_o !== 1'b0) begin errors++; $display("FAIL reset_pe got %b exp 0", pe_o); end
        checks++; if (se_o !== 1'b0) begin errors++; $display("FAIL reset_se got %b exp 0", se_o); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h exp 00", p_data); end
        reset = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_basic;
        obs_q.delete(); exp_q.delete();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL basic_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_parity;
        obs_q.delete(); exp_q.delete();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(5);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_cycles(5);
        send_frame(8'h6B, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_cycles(5);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL parity_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL parity_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_stop_err;
        obs_q.delete(); exp_q.delete();
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(5);
        send_frame(8'h81, 32, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(5);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL stop_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL stop_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_glitch;
        obs_q.delete(); exp_q.delete();
        prescale = PW'(8);
        par_en   = 1'b0;
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b0;
        idle_cycles(24);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL glitch_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL glitch_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_back_to_back;
        obs_q.delete(); exp_q.delete();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(4);
        checks++;
        if (obs_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[1].cyc - obs_q[0].cyc !== 160) begin errors++;
                $display("FAIL b2b_spacing got %0d exp 160", obs_q[1].cyc - obs_q[0].cyc); end
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL b2b_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_reset_midframe;
        int unsigned dummy;
        logic [7:0] d;
        obs_q.delete(); exp_q.delete();
        d = 8'hFF;
        prescale = PW'(16);
        par_en   = 1'b0;
        drive_cell(1'b0, 16, dummy);
        for (int i = 0; i < 4; i++) drive_cell(d[i], 16, dummy);
        repeat (5) begin @(negedge clk); rx = d[4]; end
        @(negedge clk); reset = 1'b1; rx = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_data = 8'h00;
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL midreset_dv got %b exp 0", dv); end
        checks++; if (pe_o !== 1'b0 || se_o !== 1'b0) begin errors++; $display("FAIL midreset_err got pe=%b se=%b exp 0 0", pe_o, se_o); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL midreset_pdata got %h exp 00", p_data); end
        idle_cycles(3);
        flip_mode = 1;
        send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        flip_mode = 0;
        idle_cycles(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL midreset_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL midreset_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    task automatic test_random;
        int unsigned p;
        obs_q.delete(); exp_q.delete();
        flip_mode = 2;
        scramble  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            p = 8 << $urandom_range(0, 2);
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0));
            idle_cycles($urandom_range(0, 20));
        end
        idle_cycles(4);
        flip_mode = 0;
        scramble  = 1'b0;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL random_ev%0d got cyc=%0d d=%h dv=%b pe=%b se=%b exp cyc=%0d d=%h dv=%b pe=%b se=%b", i,
                    obs_q[i].cyc, obs_q[i].data, obs_q[i].dv, obs_q[i].pe, obs_q[i].se,
                    exp_q[i].cyc, exp_q[i].data, exp_q[i].dv, exp_q[i].pe, exp_q[i].se); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_stop_err;
        test_glitch;
        test_back_to_back;
        test_reset_midframe;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- UART receiver, the receive-side counterpart of the TX path's FSM/serializer/parity/mux chain.
- Oversamples RX_IN at Prescale clocks per bit and detects the start bit, rejecting glitches.
- Majority-votes each bit, deserializes LSB-first, and checks parity and stop bit.
- Delivers a parallel byte with one-cycle valid/error strobes to the system-side sync stage.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input and the edge counter.

Ports:
- clk  input  1  receiver oversampling clock.
- reset  input  1  synchronous active-high reset; clears all state and outputs.
- RX_IN  input  1  serial line; idle high; already synchronised upstream.
- Prescale  input  PRESCALE_WIDTH  clocks per bit; legal values 8, 16, 32.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  received byte; holds its value until the next good frame.
- data_valid  output  1  one-cycle strobe: P_DATA updated, frame error-free.
- par_err  output  1  one-cycle strobe: parity mismatch.
- stp_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high. Reset dominates every other input, mid-frame included.
  - Reset values: state = IDLE, P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, all counters 0.
- Configuration capture:
  - Prescale, PAR_EN and PAR_TYP are captured when a start edge is detected.
  - The captured values govern the whole frame. Changes mid-frame are ignored.
- Counters:
  - edge_cnt runs 0..P-1 within a bit, then wraps to 0 and advances the bit phase. P is the captured Prescale.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Sampling:
  - Three samples are taken at edge_cnt = P/2-2, P/2-1 and P/2.
  - The bit value is the majority of the three, decided at edge_cnt = P/2.
- States:
  - IDLE:
    - When RX_IN = 0, go to START. That cycle counts as edge 0, so edge_cnt <= 1.
    - Otherwise stay in IDLE.
  - START:
    - If the voted value is 1, it is a glitch: go to IDLE at edge P/2+1 with no strobes.
    - Otherwise, at edge P-1 go to DATA.
  - DATA:
    - The voted bit is shifted into a shift register LSB-first.
    - At edge P-1 of bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY:
    - Expected parity = XOR of the data bits, inverted if PAR_TYP = 1.
    - A mismatch sets an internal parity-error flag.
    - At edge P-1, go to STOP.
  - STOP:
    - A voted value of 0 sets an internal stop-error flag.
    - At edge P-1, go to IDLE and issue the frame result.
- Frame result (registered outputs, asserted on the cycle after STOP edge P-1, width exactly one cycle):
  - No errors: P_DATA <= shift register and data_valid = 1.
  - Any error: P_DATA is unchanged, data_valid = 0, and par_err / stp_err reflect their flags. Both may assert together.
- Back-to-back frames:
  - IDLE is entered in the same cycle the strobes assert.
  - If RX_IN is already 0, START begins on the next cycle with no lost edge.
- Latency: the strobe occurs (1 + DATA_WIDTH + PAR_EN + 1)·P clocks after the start-edge cycle.
- Not required: behaviour for non-legal Prescale values, and break detection.
- A line held low is handled as follows:
  - It produces stp_err.
  - It then re-enters START immediately.
  - The next frame completes with stp_err, repeating until the line returns high.

Test Plan:
- Prescale = 8, PAR_EN = 0, RX_IN frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid for one cycle 80 clocks after the start edge, P_DATA = 0xA5, no errors.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C, parity bit 0 -> P_DATA = 0x3C, data_valid = 1. Repeat with parity bit 1 -> par_err = 1, data_valid = 0, P_DATA still 0x3C.
- Prescale = 32, byte 0x81 with stop bit driven 0 -> stp_err = 1 for one cycle, data_valid = 0. Then with PAR_EN = 1 and a wrong parity bit plus a low stop bit -> par_err = 1 and stp_err = 1 in the same cycle.
- Prescale = 8, RX_IN low for 2 clocks then high -> returns to IDLE with no strobes. A following valid frame 0x55 -> P_DATA = 0x55.
- Two frames back-to-back with no idle gap (0x12, then 0x34), Prescale = 16 -> two data_valid strobes exactly 160 clocks apart, P_DATA = 0x12 then 0x34.
- Assert reset during bit 4 of a frame -> next cycle all outputs 0 and state IDLE. A fresh frame 0xF0 afterwards -> P_DATA = 0xF0. One sample per bit flipped at P/2-1 -> majority still recovers the correct byte.
